redmule_z_drain: RTL
====================

REDMULE_Z_DRAIN -- requirements
Module: redmule_z_drain

Interface
REQ-001 SHALL have parameter DW, 288: memory-side data width in bits.
REQ-002 SHALL have parameter FpFormat, fpnew_pkg::FP16: element format; BITW = fp_width(FpFormat).
REQ-003 SHALL have parameter Width, ARRAY_WIDTH: W, the number of array rows and of result elements per fill.
REQ-004 SHALL derive localparam D = DW/BITW (elements per memory row; 18 at defaults) and STRBW = DW/8.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-008 SHALL have port ctrl_i, input, z_drain_ctrl_t: fill, cols_lftovr, rows_lftovr.
REQ-009 SHALL have port flags_o, output, z_drain_flgs_t: full, empty.
REQ-010 SHALL have port z_buffer_i, input, [W-1:0][BITW-1:0]: one result column from the array.
REQ-011 SHALL have port z_data_o, output, DW: packed memory row, element c at bits [c*BITW +: BITW].
REQ-012 SHALL have port z_strb_o, output, STRBW: byte strobes.
REQ-013 SHALL have ports z_valid_o (output, 1) and z_ready_i (input, 1) forming the store handshake.

Function
REQ-014 SHALL hold storage z_q[W][D][BITW] and a two-state FSM: FILL, DRAIN.
REQ-015 SHALL, in FILL on ctrl_i.fill, write z_q[w][col_idx] <= z_buffer_i[w] for all w and increment col_idx.
REQ-016 SHALL latch col_lim (cols_lftovr when nonzero, else D) and row_lim (rows_lftovr when nonzero, else W) on the fill taken at col_idx==0; mid-block ctrl changes SHALL be ignored.
REQ-017 SHALL move to DRAIN in the cycle after the fill that makes col_idx==col_lim; flags_o.full SHALL be 1 exactly while in DRAIN.
REQ-018 SHALL ignore ctrl_i.fill while in DRAIN, including a fill coincident with the final handshake.
REQ-019 SHALL, in DRAIN, assert z_valid_o and drive z_data_o from z_q[row_idx], with elements c >= col_lim forced to zero.
REQ-020 SHALL increment row_idx on z_valid_o && z_ready_i; after the handshake at row_idx==row_lim-1 it SHALL zero both counters and return to FILL in the next cycle.
REQ-021 SHALL keep z_valid_o, z_data_o, z_strb_o and row_idx stable while z_ready_i is low.
REQ-022 SHALL assert flags_o.empty iff state==FILL and col_idx==0.
REQ-023 SHALL, on clear_i (highest priority over fill and handshake), zero z_q, col_idx and row_idx, and enter FILL next cycle.
REQ-024 SHALL drive z_data_o to zero and z_valid_o to 0 in FILL.

Reset
REQ-025 SHALL, while rst_i is high, force FILL, zero counters and z_q, and hold outputs at: z_valid_o 0, z_data_o 0, z_strb_o 0, full 0, empty 1.
REQ-026 SHALL abandon any partially filled or drained block on reset, with no handshake completing.

Configuration
REQ-027 SHALL, with REDMULE_Z_STRB_EN defined, set z_strb_o byte j in DRAIN iff j < col_lim*BITW/8.
REQ-028 SHALL, without REDMULE_Z_STRB_EN, tie z_strb_o to all ones in DRAIN; the port SHALL exist in both builds.

Structure
REQ-029 SHALL take z_drain_ctrl_t and z_drain_flgs_t from redmule_pkg, with cols_lftovr and rows_lftovr widths matching x_buffer_ctrl_t.
REQ-030 SHALL use one sub-module, redmule_z_drain_ctrl, holding the FSM, counters and limit latches; the datapath stays in the top.

Verification
REQ-031 Full block (defaults W=12, D=18): 18 fills with z_buffer_i[w]=16'h(w<<8|c), ready=1 -> full 1 cycle after last fill; 12 beats; beat w element c = 16'h(w<<8|c); then empty=1.
REQ-032 Backpressure: ready low 5 cycles at row 3 -> valid stays 1, data stable for all 5 cycles, row 3 sent once.
REQ-033 Leftovers cols_lftovr=5, rows_lftovr=7 -> full after 5 fills; 7 beats; elements 5..17 zero; strb = 36'h3FF with macro, all ones without.
REQ-034 Fill during DRAIN and fill coincident with the last handshake -> no storage change; next block starts at col_idx 0.
REQ-035 clear_i at row 4 of a drain -> next cycle valid 0, full 0, empty 1, z_data_o 0.
REQ-036 rst_i pulsed asynchronously after 9 fills -> outputs at reset values immediately; a following 18-fill block drains correctly.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Floating-point format enumeration and width helper used to size the Z drain elements.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32,
      FP64,
      FP16,
      FP8,
      FP16ALT
   } fp_format_e;

   function automatic int unsigned fp_width(fp_format_e fmt);
      case (fmt)
         FP32:    return 32;
         FP64:    return 64;
         FP16:    return 16;
         FP8:     return 8;
         FP16ALT: return 16;
         default: return 16;
      endcase
   endfunction

endpackage

// File: rtl/redmule_pkg.sv
// Shared RedMulE types: buffer control/flag structs and the Z drain FSM state encoding.
package redmule_pkg;

   localparam int unsigned ARRAY_WIDTH = 12;
   localparam int unsigned LFTOVR_W    = 6;

   typedef struct packed {
      logic [LFTOVR_W-1:0] rows_lftovr;
      logic [LFTOVR_W-1:0] cols_lftovr;
   } x_buffer_ctrl_t;

   typedef struct packed {
      logic                fill;
      logic [LFTOVR_W-1:0] cols_lftovr;
      logic [LFTOVR_W-1:0] rows_lftovr;
   } z_drain_ctrl_t;

   typedef struct packed {
      logic full;
      logic empty;
   } z_drain_flgs_t;

   typedef enum logic {
      Z_FILL,
      Z_DRAIN
   } z_drain_state_e;

endpackage

// File: rtl/redmule_z_drain_if.sv
// Store-side bus of the Z drain: packed row, byte strobes and valid/ready handshake.
interface redmule_z_drain_if #(
   parameter int unsigned DW    = 288,
   parameter int unsigned STRBW = DW/8
);
   logic [DW-1:0]    z_data;
   logic [STRBW-1:0] z_strb;
   logic             z_valid;
   logic             z_ready;

   modport master (output z_data, output z_strb, output z_valid, input z_ready);
   modport slave  (input z_data, input z_strb, input z_valid, output z_ready);
endinterface

// File: rtl/redmule_z_drain_ctrl.sv
// Z drain control: FILL/DRAIN FSM, column/row counters and per-block limit latches.
module redmule_z_drain_ctrl
   import redmule_pkg::*;
#(
   parameter  int unsigned W   = ARRAY_WIDTH,
   parameter  int unsigned D   = 18,
   localparam int unsigned CW  = $clog2(D+1),
   localparam int unsigned RW  = $clog2(W),
   localparam int unsigned RLW = RW+1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  z_drain_ctrl_t   ctrl,
   redmule_z_drain_if.master store,
   output z_drain_flgs_t   flags,
   output logic            wr_en,
   output logic            drain,
   output logic [CW-1:0]   col_idx,
   output logic [CW-1:0]   col_lim,
   output logic [RW-1:0]   row_idx
);

   z_drain_state_e state_q, state_d;
   logic [CW-1:0]  col_idx_q, col_idx_d, col_lim_q, col_lim_d;
   logic [RW-1:0]  row_idx_q, row_idx_d;
   logic [RLW-1:0] row_lim_q, row_lim_d;

   // Zero or out-of-range leftovers mean a full block.
   function automatic logic [CW-1:0] pick_col(logic [LFTOVR_W-1:0] l);
      if (l != '0 && 32'(l) <= D) return CW'(l);
      return CW'(D);
   endfunction

   function automatic logic [RLW-1:0] pick_row(logic [LFTOVR_W-1:0] l);
      if (l != '0 && 32'(l) <= W) return RLW'(l);
      return RLW'(W);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= Z_FILL;
         col_idx_q <= '0;
         row_idx_q <= '0;
         col_lim_q <= CW'(D);
         row_lim_q <= RLW'(W);
      end else begin
         state_q   <= state_d;
         col_idx_q <= col_idx_d;
         row_idx_q <= row_idx_d;
         col_lim_q <= col_lim_d;
         row_lim_q <= row_lim_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      col_lim_d = col_lim_q;
      row_lim_d = row_lim_q;
      wr_en     = 1'b0;
      if (clear_i) begin
         state_d   = Z_FILL;
         col_idx_d = '0;
         row_idx_d = '0;
      end else begin
         case (state_q)
            Z_FILL: begin
               if (ctrl.fill) begin
                  wr_en = 1'b1;
                  if (col_idx_q == '0) begin
                     col_lim_d = pick_col(ctrl.cols_lftovr);
                     row_lim_d = pick_row(ctrl.rows_lftovr);
                  end
                  col_idx_d = col_idx_q + 1'b1;
                  if (col_idx_d == col_lim_d) state_d = Z_DRAIN;
               end
            end
            Z_DRAIN: begin
               if (store.z_ready) begin
                  if ({1'b0, row_idx_q} == row_lim_q - 1'b1) begin
                     row_idx_d = '0;
                     col_idx_d = '0;
                     state_d   = Z_FILL;
                  end else begin
                     row_idx_d = row_idx_q + 1'b1;
                  end
               end
            end
            default: state_d = Z_FILL;
         endcase
      end
   end

   assign drain         = (state_q == Z_DRAIN);
   assign store.z_valid = drain;
   assign flags.full    = drain;
   assign flags.empty   = (state_q == Z_FILL) && (col_idx_q == '0);
   assign col_idx       = col_idx_q;
   assign col_lim       = col_lim_q;
   assign row_idx       = row_idx_q;

endmodule

// File: rtl/redmule_z_drain.sv
// Z result drain: buffers W x D result elements column by column and streams them out row by row.
// Optional macro REDMULE_Z_STRB_EN restricts byte strobes to the valid columns of the block.
module redmule_z_drain
   import redmule_pkg::*;
#(
   parameter  int unsigned           DW       = 288,
   parameter  fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
   parameter  int unsigned           Width    = ARRAY_WIDTH,
   localparam int unsigned           BITW     = fpnew_pkg::fp_width(FpFormat),
   localparam int unsigned           W        = Width,
   localparam int unsigned           D        = DW/BITW,
   localparam int unsigned           STRBW    = DW/8,
   localparam int unsigned           CW       = $clog2(D+1),
   localparam int unsigned           RW       = $clog2(W)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  z_drain_ctrl_t             ctrl_i,
   output z_drain_flgs_t             flags_o,
   input  logic [W-1:0][BITW-1:0]    z_buffer_i,
   output logic [DW-1:0]             z_data_o,
   output logic [STRBW-1:0]          z_strb_o,
   output logic                      z_valid_o,
   input  logic                      z_ready_i
);

   redmule_z_drain_if #(.DW(DW), .STRBW(STRBW)) store_if ();

   logic            wr_en, drain;
   logic [CW-1:0]   col_idx, col_lim;
   logic [RW-1:0]   row_idx;
   logic [BITW-1:0] z_q [W][D];
   logic [DW-1:0]   z_data;
   logic [STRBW-1:0] z_strb;

   redmule_z_drain_ctrl #(.W(W), .D(D)) i_ctrl (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .ctrl    (ctrl_i),
      .store   (store_if),
      .flags   (flags_o),
      .wr_en   (wr_en),
      .drain   (drain),
      .col_idx (col_idx),
      .col_lim (col_lim),
      .row_idx (row_idx)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned w = 0; w < W; w++)
            for (int unsigned c = 0; c < D; c++)
               z_q[w][c] <= '0;
      end else if (clear_i) begin
         for (int unsigned w = 0; w < W; w++)
            for (int unsigned c = 0; c < D; c++)
               z_q[w][c] <= '0;
      end else if (wr_en) begin
         for (int unsigned w = 0; w < W; w++)
            z_q[w][col_idx] <= z_buffer_i[w];
      end
   end

   // Columns past the block limit hold stale data from earlier blocks, so they are masked.
   always_comb begin
      z_data = '0;
      z_strb = '0;
      if (drain) begin
         for (int unsigned c = 0; c < D; c++)
            if (c < 32'(col_lim)) z_data[c*BITW +: BITW] = z_q[row_idx][c];
`ifdef REDMULE_Z_STRB_EN
         for (int unsigned j = 0; j < STRBW; j++)
            z_strb[j] = (j < 32'(col_lim) * (BITW/8));
`else
         z_strb = '1;
`endif
      end
   end

   assign store_if.z_data  = z_data;
   assign store_if.z_strb  = z_strb;
   assign store_if.z_ready = z_ready_i;
   assign z_data_o         = store_if.z_data;
   assign z_strb_o         = store_if.z_strb;
   assign z_valid_o        = store_if.z_valid;

endmodule
